// File: rtl/riscv_pkg.sv
// Shared bus layouts, widths, access-size encodings and FSM states for the memory stage.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package riscv_pkg;

    localparam int EX_MEM_W = 108;
    localparam int MEM_WB_W = 70;
    localparam int FWD_W    = 39;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_MEM  = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [31:0] pc;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rd_wen;
        logic [31:0] wb_data;
        logic [31:0] pc;
    } mem_wb_t;

    typedef struct packed {
        logic        load_pending;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [31:0] data;
    } fwd_t;

    // Size 11 behaves as a word access everywhere, so it shares the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects and extends the addressed byte/half/word from a 32-bit memory read.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then zero- or sign-extend it to 32 bits.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (size)
            SIZE_BYTE: result = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
            SIZE_HALF: result = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: holds one EX->MEM instruction, runs its data-memory access, emits one MEM->WB beat.
// Latency: non-memory op beats 1 cycle after capture; memory op beats in the ack cycle (earliest 1 cycle after capture).
// Backpressure: mem_allowin drops while a request is outstanding and rises combinationally with dmem_ack.
module mem_stage
    import riscv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [EX_MEM_W-1:0] ex_mem_bus_in,
    output logic                mem_allowin,
    output logic [MEM_WB_W-1:0] mem_wb_bus_out,
    output logic [FWD_W-1:0]    fwd_bus_out,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [31:0]         dmem_addr,
    output logic [3:0]          dmem_wstrb,
    output logic [31:0]         dmem_wdata,
    input  logic                dmem_ack,
    input  logic [31:0]         dmem_rdata,
    output logic                misalign_err
);

    ex_mem_t    in_bus;
    ex_mem_t    r_q;
    logic       mis_q;
    mem_state_t state_q;
    mem_state_t state_d;

    logic       in_mem_op;
    logic       in_mis;
    logic       r_is_load;
    logic [31:0] ld_data;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    mem_wb_t     beat;
    fwd_t        fwd;

    assign in_bus    = ex_mem_bus_in;
    assign in_mem_op = in_bus.mem_ren | in_bus.mem_wen;
    assign in_mis    = in_mem_op & is_misaligned(in_bus.mem_size, in_bus.alu_result[1:0]);
    // A write bit wins if both are set, so a combined op never writes back.
    assign r_is_load = r_q.mem_ren & ~r_q.mem_wen;

    load_align u_load_align (
        .rdata       (dmem_rdata),
        .addr_lo     (r_q.alu_result[1:0]),
        .size        (r_q.mem_size),
        .is_unsigned (r_q.mem_unsigned),
        .result      (ld_data)
    );

    // Classify the incoming instruction whenever EX is allowed to hand one over.
    always_comb begin
        state_d = state_q;
        if (mem_allowin) begin
            if (!in_bus.valid) begin
                state_d = ST_IDLE;
            end else if (in_mem_op && !in_mis) begin
                state_d = ST_MEM;
            end else begin
                state_d = ST_PASS;
            end
        end
    end

    // Stage register and state; an empty slot is held as all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mem_allowin) begin
                r_q   <= in_bus.valid ? in_bus : '0;
                mis_q <= in_bus.valid & in_mis;
            end
        end
    end

    // Store lane strobes and replicated write data, derived from the held instruction.
    always_comb begin
        case (r_q.mem_size)
            SIZE_BYTE: begin
                st_strb = 4'b0001 << r_q.alu_result[1:0];
                st_data = {4{r_q.store_data[7:0]}};
            end
            SIZE_HALF: begin
                st_strb = r_q.alu_result[1] ? 4'b1100 : 4'b0011;
                st_data = {2{r_q.store_data[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = r_q.store_data;
            end
        endcase
    end

    // Per-state outputs: writeback beat, forwarding view, memory request, handshake.
    always_comb begin
        mem_allowin  = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = 32'h0;
        dmem_wstrb   = 4'h0;
        dmem_wdata   = 32'h0;
        misalign_err = 1'b0;
        beat         = '0;
        fwd          = '0;
        case (state_q)
            ST_IDLE: begin
                mem_allowin = 1'b1;
            end
            ST_PASS: begin
                mem_allowin = 1'b1;
                beat.rd     = r_q.rd;
                beat.pc     = r_q.pc;
                if (mis_q) begin
                    misalign_err = 1'b1;
                end else begin
                    beat.rd_wen  = r_q.rd_wen;
                    beat.wb_data = r_q.alu_result;
                end
                fwd.rd     = beat.rd;
                fwd.rd_wen = beat.rd_wen;
                fwd.data   = beat.wb_data;
            end
            ST_MEM: begin
                mem_allowin = dmem_ack;
                // MEM is only ever entered with a valid instruction held.
                dmem_req    = r_q.valid;
                dmem_we     = r_q.mem_wen;
                dmem_addr   = {r_q.alu_result[31:2], 2'b00};
                if (r_q.mem_wen) begin
                    dmem_wstrb = st_strb;
                    dmem_wdata = st_data;
                end
                if (dmem_ack) begin
                    beat.rd = r_q.rd;
                    beat.pc = r_q.pc;
                    if (r_is_load) begin
                        beat.rd_wen  = r_q.rd_wen;
                        beat.wb_data = ld_data;
                    end
                end
                fwd.load_pending = r_is_load & ~dmem_ack;
                fwd.rd           = r_q.rd;
                fwd.rd_wen       = r_is_load & r_q.rd_wen;
                fwd.data         = beat.wb_data;
            end
            default: begin
                mem_allowin = 1'b1;
            end
        endcase
    end

    assign mem_wb_bus_out = beat;
    assign fwd_bus_out    = fwd;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset-in-flight sequence, random stream vs model.
// Latency: n/a.
// Backpressure: EX side holds its bus whenever the model says allowin is low.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [107:0] ex_bus;
    logic         allowin;
    logic [69:0]  wb_bus;
    logic [38:0]  fwd_bus;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [3:0]   dmem_wstrb;
    logic [31:0]  dmem_wdata;
    logic         dmem_ack;
    logic [31:0]  dmem_rdata;
    logic         misalign_err;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_mem_bus_in  (ex_bus),
        .mem_allowin    (allowin),
        .mem_wb_bus_out (wb_bus),
        .fwd_bus_out    (fwd_bus),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .misalign_err   (misalign_err)
    );

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        ren;
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] pc;
    } ins_t;

    typedef struct {
        ins_t        ins;
        int          wait_n;
        logic [31:0] rdata;
        logic [31:0] exp_wb;
        logic        exp_wen;
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ins_t mk(input logic [4:0] rd, input logic rw, input logic ren, input logic wen,
                                input logic [1:0] sz, input logic uns, input logic [31:0] alu,
                                input logic [31:0] sd, input logic [31:0] pc);
        ins_t i;
        i = {1'b1, rd, rw, ren, wen, sz, uns, alu, sd, pc};
        return i;
    endfunction

    // ---------------- reference model (from the access rules, plain arithmetic) ----------------
    function automatic bit m_memop(input ins_t i);
        return i.ren || i.wen;
    endfunction

    function automatic bit m_mis(input ins_t i);
        int unsigned lo;
        lo = i.alu % 4;
        if (!m_memop(i)) return 1'b0;
        if (i.size == 2'd0) return 1'b0;
        if (i.size == 2'd1) return (lo % 2) != 0;
        return lo != 0;
    endfunction

    function automatic bit m_access(input ins_t i);
        return m_memop(i) && !m_mis(i);
    endfunction

    function automatic bit m_load(input ins_t i);
        return i.ren && !i.wen;
    endfunction

    function automatic logic [31:0] m_fmt(input ins_t i, input logic [31:0] rdv);
        logic [31:0] v;
        int unsigned sh;
        if (i.size == 2'd0) begin
            sh = (i.alu % 4) * 8;
            v  = (rdv >> sh) & 32'hFF;
            if (!i.uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (i.size == 2'd1) begin
            sh = ((i.alu % 4) / 2) * 16;
            v  = (rdv >> sh) & 32'hFFFF;
            if (!i.uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdv;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input ins_t i);
        if (i.size == 2'd0) return 4'(1 << (i.alu % 4));
        if (i.size == 2'd1) return ((i.alu % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input ins_t i);
        if (i.size == 2'd0) return (i.sd & 32'hFF) * 32'h0101_0101;
        if (i.size == 2'd1) return (i.sd & 32'hFFFF) * 32'h0001_0001;
        return i.sd;
    endfunction

    function automatic logic [69:0] m_beat(input ins_t i, input logic [31:0] rdv);
        if (m_mis(i))        return {i.rd, 1'b0, 32'h0, i.pc};
        if (m_load(i))       return {i.rd, i.rd_wen, m_fmt(i, rdv), i.pc};
        if (m_memop(i))      return {i.rd, 1'b0, 32'h0, i.pc};
        return {i.rd, i.rd_wen, i.alu, i.pc};
    endfunction

    // Store write-data on the retire beat is not defined, so it is excluded.
    function automatic logic [69:0] m_mask(input ins_t i);
        logic [69:0] m;
        m = '1;
        if (m_access(i) && !m_load(i)) m[63:32] = 32'h0;
        return m;
    endfunction

    // ---------------- directed vector runner ----------------
    task automatic run_vec(input vec_t v, input string nm);
        bit acc;
        acc        = m_access(v.ins);
        ex_bus     = v.ins;
        dmem_ack   = 1'b0;
        dmem_rdata = v.rdata;
        @(negedge clk);
        chk({nm, "_allow_pre"}, 70'(allowin), 70'(1));
        @(posedge clk); #1;
        ex_bus = '0;
        for (int c = 0; c <= v.wait_n; c++) begin
            dmem_ack = acc && (c == v.wait_n);
            @(negedge clk);
            if (acc) begin
                chk({nm, "_req"}, 70'(dmem_req), 70'(1));
                chk({nm, "_addr"}, 70'(dmem_addr), 70'(v.exp_addr));
                chk({nm, "_we"}, 70'(dmem_we), 70'(v.ins.wen));
                if (v.ins.wen) begin
                    chk({nm, "_wstrb"}, 70'(dmem_wstrb), 70'(v.exp_strb));
                    chk({nm, "_wdata"}, 70'(dmem_wdata), 70'(v.exp_wdata));
                end
            end else begin
                chk({nm, "_noreq"}, 70'(dmem_req), 70'(0));
            end
            if (acc && c < v.wait_n) begin
                chk({nm, "_wait_bubble"}, wb_bus, 70'(0));
                chk({nm, "_wait_allow"}, 70'(allowin), 70'(0));
                chk({nm, "_wait_ldpend"}, 70'(fwd_bus[38]), 70'(m_load(v.ins)));
            end else begin
                chk({nm, "_rd"}, 70'(wb_bus[69:65]), 70'(v.ins.rd));
                chk({nm, "_rdwen"}, 70'(wb_bus[64]), 70'(v.exp_wen));
                if (!(acc && v.ins.wen)) chk({nm, "_wbdata"}, 70'(wb_bus[63:32]), 70'(v.exp_wb));
                chk({nm, "_pc"}, 70'(wb_bus[31:0]), 70'(v.ins.pc));
                chk({nm, "_mis"}, 70'(misalign_err), 70'(v.exp_mis));
                chk({nm, "_allow"}, 70'(allowin), 70'(1));
                chk({nm, "_ldpend"}, 70'(fwd_bus[38]), 70'(0));
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        @(negedge clk);
        chk({nm, "_post_bubble"}, wb_bus, 70'(0));
        chk({nm, "_post_mis"}, 70'(misalign_err), 70'(0));
        chk({nm, "_post_req"}, 70'(dmem_req), 70'(0));
        @(posedge clk); #1;
    endtask

    function automatic ins_t rand_ins(input int cyc);
        ins_t i;
        int   kind;
        i       = '0;
        i.valid = ($urandom % 10) != 0;
        i.rd    = 5'($urandom);
        i.rd_wen = 1'($urandom);
        i.size  = 2'($urandom);
        i.uns   = 1'($urandom);
        i.alu   = $urandom;
        i.sd    = $urandom;
        i.pc    = 32'h1000 + 32'(cyc) * 4;
        kind    = $urandom % 3;
        i.ren   = (kind == 1);
        i.wen   = (kind == 2);
        return i;
    endfunction

    vec_t vecs[12];

    initial begin
        ins_t pres;
        ins_t cur;
        bit   have;
        bit   take;
        bit   mem_pend;
        bit   exp_allow;
        bit   beat_due;
        logic [69:0] eb;
        logic [69:0] mk_;

        vecs[0]  = '{mk(5, 1, 0, 0, 2'd2, 0, 32'h1234, 32'h0, 32'h80), 0, 32'h0,
                     32'h1234, 1, 0, 32'h0, 4'h0, 32'h0};
        vecs[1]  = '{mk(7, 1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h84), 3, 32'h80FF_0000,
                     32'hFFFF_FF80, 1, 0, 32'h100, 4'h0, 32'h0};
        vecs[2]  = '{mk(8, 1, 1, 0, 2'd1, 1, 32'h102, 32'h0, 32'h88), 0, 32'hBEEF_1234,
                     32'h0000_BEEF, 1, 0, 32'h100, 4'h0, 32'h0};
        vecs[3]  = '{mk(9, 0, 0, 1, 2'd0, 0, 32'h201, 32'hAB, 32'h8C), 1, 32'h0,
                     32'h0, 0, 0, 32'h200, 4'b0010, 32'hABAB_ABAB};
        vecs[4]  = '{mk(10, 1, 1, 0, 2'd2, 0, 32'h106, 32'h0, 32'h90), 0, 32'h0,
                     32'h0, 0, 1, 32'h0, 4'h0, 32'h0};
        vecs[5]  = '{mk(11, 0, 0, 1, 2'd1, 0, 32'h202, 32'h1234_CAFE, 32'h94), 0, 32'h0,
                     32'h0, 0, 0, 32'h200, 4'hC, 32'hCAFE_CAFE};
        vecs[6]  = '{mk(12, 1, 1, 0, 2'd1, 0, 32'h100, 32'h0, 32'h98), 2, 32'h0000_8001,
                     32'hFFFF_8001, 1, 0, 32'h100, 4'h0, 32'h0};
        vecs[7]  = '{mk(13, 1, 1, 0, 2'd0, 1, 32'h101, 32'h0, 32'h9C), 0, 32'h0000_F000,
                     32'h0000_00F0, 1, 0, 32'h100, 4'h0, 32'h0};
        vecs[8]  = '{mk(14, 1, 1, 0, 2'd3, 0, 32'h104, 32'h0, 32'hA0), 1, 32'hDEAD_BEEF,
                     32'hDEAD_BEEF, 1, 0, 32'h104, 4'h0, 32'h0};
        vecs[9]  = '{mk(15, 0, 0, 1, 2'd2, 0, 32'h300, 32'h1122_3344, 32'hA4), 0, 32'h0,
                     32'h0, 0, 0, 32'h300, 4'hF, 32'h1122_3344};
        vecs[10] = '{mk(16, 1, 1, 0, 2'd1, 0, 32'h103, 32'h0, 32'hA8), 0, 32'h0,
                     32'h0, 0, 1, 32'h0, 4'h0, 32'h0};
        vecs[11] = '{mk(17, 0, 0, 1, 2'd1, 0, 32'h201, 32'h55, 32'hAC), 0, 32'h0,
                     32'h0, 0, 1, 32'h0, 4'h0, 32'h0};

        rst        = 1'b1;
        ex_bus     = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_allow", 70'(allowin), 70'(1));
        chk("reset_bus", wb_bus, 70'(0));
        chk("reset_fwd", 70'(fwd_bus), 70'(0));
        chk("reset_req", 70'({dmem_req, dmem_we, dmem_wstrb}), 70'(0));
        chk("reset_addr_wdata", 70'({dmem_addr, dmem_wdata}), 70'(0));
        chk("reset_mis", 70'(misalign_err), 70'(0));
        @(posedge clk); #1;

        for (int k = 0; k < 12; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Reset while a load waits; a late ack must be ignored.
        ex_bus = mk(3, 1, 1, 0, 2'd2, 0, 32'h400, 32'h0, 32'hB0);
        @(posedge clk); #1;
        ex_bus = '0;
        @(negedge clk);
        chk("rstmem_req_before", 70'(dmem_req), 70'(1));
        chk("rstmem_allow_before", 70'(allowin), 70'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rstmem_req", 70'(dmem_req), 70'(0));
        chk("rstmem_bus", wb_bus, 70'(0));
        chk("rstmem_allow", 70'(allowin), 70'(1));
        chk("rstmem_fwd", 70'(fwd_bus), 70'(0));
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("rstmem_bus2", wb_bus, 70'(0));
        chk("rstmem_mis2", 70'(misalign_err), 70'(0));
        @(posedge clk); #1;

        // Random stream: the model holds at most one instruction in the stage.
        have = 1'b0;
        take = 1'b1;
        cur  = '0;
        pres = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (take) pres = rand_ins(cyc);
            ex_bus     = pres;
            dmem_ack   = dmem_req ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
            dmem_rdata = $urandom;
            @(negedge clk);
            mem_pend  = have && m_access(cur);
            exp_allow = !mem_pend || dmem_ack;
            beat_due  = have && (!m_access(cur) || dmem_ack);
            chk("rnd_req", 70'(dmem_req), 70'(mem_pend));
            chk("rnd_allow", 70'(allowin), 70'(exp_allow));
            if (mem_pend) begin
                chk("rnd_addr", 70'({dmem_we, dmem_addr}), 70'({cur.wen, cur.alu[31:2], 2'b00}));
                if (cur.wen) chk("rnd_store", 70'({dmem_wstrb, dmem_wdata}), 70'({m_strb(cur), m_wdata(cur)}));
            end
            if (beat_due) begin
                eb  = m_beat(cur, dmem_rdata);
                mk_ = m_mask(cur);
                chk("rnd_beat", wb_bus & mk_, eb & mk_);
                chk("rnd_mis", 70'(misalign_err), 70'(m_mis(cur)));
                chk("rnd_fwd", 70'({fwd_bus[38], fwd_bus[31:0]} & {1'b1, mk_[63:32]}),
                               70'({1'b0, eb[63:32] & mk_[63:32]}));
            end else begin
                chk("rnd_bubble", 70'({wb_bus, misalign_err}), 70'(0));
                chk("rnd_ldpend", 70'(fwd_bus[38]), 70'(have && m_load(cur)));
                if (!have) chk("rnd_fwd_idle", 70'(fwd_bus), 70'(0));
            end
            if (beat_due) have = 1'b0;
            take = exp_allow;
            if (exp_allow && pres.valid) begin
                have = 1'b1;
                cur  = pres;
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
